// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcodes, register-address width and scoreboard entry type for the
// pipeline hazard scheduler.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_J       = 6'b000010;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_MA = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_decode.sv
// Register-usage decode of the ID-stage instruction: destination, whether it
// writes, and which source fields it reads.
module pipe_insn_decode
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [5:0]            i_op,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_writes,
  output logic [REG_ADDR_W-1:0] o_dest,
  output logic                  o_uses_rs,
  output logic                  o_uses_rt
);

  logic w_wr;

  always_comb begin
    w_wr      = 1'b0;
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    case (i_op)
      OP_SPECIAL: begin w_wr = 1'b1; o_uses_rs = 1'b1; o_uses_rt = 1'b1; end
      OP_LW:      begin w_wr = 1'b1; o_uses_rs = 1'b1; end
      OP_SW:      begin o_uses_rs = 1'b1; o_uses_rt = 1'b1; end
      OP_BEQ:     begin o_uses_rs = 1'b1; o_uses_rt = 1'b1; end
      OP_ADDI:    begin w_wr = 1'b1; o_uses_rs = 1'b1; end
      OP_ORI:     begin w_wr = 1'b1; o_uses_rs = 1'b1; end
      OP_LUI:     begin w_wr = 1'b1; end
      default:    begin end
    endcase
  end

  assign o_dest   = (i_op == OP_SPECIAL) ? i_rd : i_rt;
  // $0 is hardwired, so a write to it can never create a dependency
  assign o_writes = w_wr & (o_dest != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard scheduler: shift-register scoreboard of in-flight destinations,
// stall/flush/bubble generation and a saturating stall counter.
// Optional build macro PIPE_FORWARD_EN: load-use-only stalls plus EX operand
// forwarding selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH          = 3,
  parameter int RF_WRITE_FIRST = 0,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   id_valid,
  input  logic [5:0]             id_op,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ex_is_load,
  input  logic                   br_taken,
  output logic                   stall_if,
  output logic                   flush_id,
  output logic                   bubble_ex,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef PIPE_FORWARD_EN
  ,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel
`endif
);

  // With write-before-read register file the WB slot is already visible to ID
  localparam logic [DEPTH-1:0] CMP_MASK =
    {DEPTH{1'b1}} >> ((RF_WRITE_FIRST != 0) ? 1 : 0);

  sb_entry_t                  r_slot [DEPTH];
  logic [STALL_CNT_W-1:0]     r_cnt;
  logic                       w_writes;
  logic [REG_ADDR_W-1:0]      w_dest;
  logic                       w_uses_rs;
  logic                       w_uses_rt;
  logic [DEPTH-1:0]           w_hit;
  logic                       w_hazard;

  function automatic logic [STALL_CNT_W-1:0] f_sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pipe_insn_decode u_dec (
    .i_op      (id_op),
    .i_rt      (id_rt),
    .i_rd      (id_rd),
    .o_writes  (w_writes),
    .o_dest    (w_dest),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt)
  );

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_slot[i].valid) begin
        w_hit[i] = (w_uses_rs && (id_rs != '0) && (id_rs == r_slot[i].dest)) ||
                   (w_uses_rt && (id_rt != '0) && (id_rt == r_slot[i].dest));
      end
    end
  end

`ifdef PIPE_FORWARD_EN
  // Only a load in EX cannot be forwarded in time
  assign w_hazard = id_valid & w_hit[0] & ex_is_load;
`else
  logic w_unused_ex_load;
  assign w_unused_ex_load = ex_is_load;
  assign w_hazard = id_valid & (|(w_hit & CMP_MASK));
`endif

  assign stall_if  = w_hazard & ~br_taken;
  assign bubble_ex = stall_if | br_taken;
  assign flush_id  = br_taken;
  assign stall_cnt = r_cnt;

  // ID -> EX boundary: scoreboard advances one stage per cycle
  always_ff @(posedge CLK) begin
    r_slot[0].dest <= w_dest;
    for (int i = 1; i < DEPTH; i++) r_slot[i].dest <= r_slot[i-1].dest;
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i].valid <= 1'b0;
    end else begin
      r_slot[0].valid <= ~bubble_ex & id_valid & w_writes;
      for (int i = 1; i < DEPTH; i++) r_slot[i].valid <= r_slot[i-1].valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n)        r_cnt <= '0;
    else if (stall_if) r_cnt <= f_sat_inc(r_cnt);
  end

`ifdef PIPE_FORWARD_EN
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;

  function automatic logic [1:0] f_fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input sb_entry_t ma, input sb_entry_t wb);
    if ((src != '0) && ma.valid && (ma.dest == src)) return FWD_MA;
    if ((src != '0) && wb.valid && (wb.dest == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  // Source copies travel with the instruction into EX; bubbles carry none
  always_ff @(posedge CLK) begin
    r_ex_rs <= (bubble_ex || !w_uses_rs) ? '0 : id_rs;
    r_ex_rt <= (bubble_ex || !w_uses_rt) ? '0 : id_rt;
  end

  assign fwd_a_sel = f_fwd_sel(r_ex_rs, r_slot[1], r_slot[2]);
  assign fwd_b_sel = f_fwd_sel(r_ex_rt, r_slot[1], r_slot[2]);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (compare-all and write-first RF)
// against a register-age reference model, directed steps then random traffic.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [5:0]  id_op = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_is_load = 1'b0;
  logic        br_taken = 1'b0;

  logic        so0, fl0, bu0, so1, fl1, bu1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;
`ifdef PIPE_FORWARD_EN
  logic [1:0]  fa0, fb0, fa1, fb1;
`endif

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.DEPTH(3), .RF_WRITE_FIRST(0), .STALL_CNT_W(4)) dut0 (
    .CLK(CLK), .RST_n(RST_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
    .stall_if(so0), .flush_id(fl0), .bubble_ex(bu0), .stall_cnt(cnt0)
`ifdef PIPE_FORWARD_EN
    , .fwd_a_sel(fa0), .fwd_b_sel(fb0)
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(3), .RF_WRITE_FIRST(1), .STALL_CNT_W(16)) dut1 (
    .CLK(CLK), .RST_n(RST_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
    .stall_if(so1), .flush_id(fl1), .bubble_ex(bu1), .stall_cnt(cnt1)
`ifdef PIPE_FORWARD_EN
    , .fwd_a_sel(fa1), .fwd_b_sel(fb1)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  // Reference model: cycle at which each register's latest producer left ID
  int lw0 [32];
  int lw1 [32];
  int mcnt0, mcnt1;
  int cyc = 0;
  bit last_s0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mdec(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                               output bit wr, output int dst, output bit urs, output bit urt);
    wr  = op inside {6'b000000, 6'b100011, 6'b001000, 6'b001101, 6'b001111};
    urs = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101};
    urt = op inside {6'b000000, 6'b101011, 6'b000100};
    dst = (op == 6'b000000) ? int'(rd) : int'(rt);
    if (dst == 0) wr = 0;
  endfunction

  // A producer that left ID at cycle c blocks readers during cycles c+1..c+win
  function automatic bit mhaz(input int lw [32], input int win, input bit v,
                              input bit urs, input bit urt, input int rs, input int rt);
    bit h = 0;
    if (v && urs && rs != 0 && (cyc - lw[rs]) <= win) h = 1;
    if (v && urt && rt != 0 && (cyc - lw[rt]) <= win) h = 1;
    return h;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin lw0[i] = -100; lw1[i] = -100; end
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input bit br, input bit rn);
    bit wr, urs, urt, h0, h1, s0, s1, b0, b1;
    int dst;
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    br_taken = br; RST_n = rn; ex_is_load = 1'($urandom_range(0, 1));
    #2;
    mdec(op, rt, rd, wr, dst, urs, urt);
    h0 = mhaz(lw0, 3, v, urs, urt, int'(rs), int'(rt));
    h1 = mhaz(lw1, 2, v, urs, urt, int'(rs), int'(rt));
    s0 = h0 & ~br;  b0 = s0 | br;
    s1 = h1 & ~br;  b1 = s1 | br;
    chk("stall_if0", so0, s0);
    chk("bubble_ex0", bu0, b0);
    chk("flush_id0", fl0, br);
    chk("stall_cnt0", cnt0, mcnt0);
    chk("stall_if1", so1, s1);
    chk("bubble_ex1", bu1, b1);
    chk("flush_id1", fl1, br);
    chk("stall_cnt1", cnt1, mcnt1);
    last_s0 = s0;
    @(posedge CLK);
    if (!rn) mreset();
    else begin
      if (s0 && mcnt0 < 15) mcnt0++;
      if (s1 && mcnt1 < 65535) mcnt1++;
      if (!b0 && v && wr) lw0[dst] = cyc;
      if (!b1 && v && wr) lw1[dst] = cyc;
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] cop;
    logic [4:0] crs, crt, crd;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b001101, 6'b001111, 6'b000010, 6'b111111};
    mreset();
    @(posedge CLK);
    cyc++;
    #1;

    // Reset held two cycles
    step(0, 6'h00, 0, 0, 0, 0, 0);
    step(0, 6'h00, 0, 0, 0, 0, 0);

    // ADD $3,$1,$2 then SUB $5,$3,$4 held in ID until released
    step(1, 6'b000000, 5'd1, 5'd2, 5'd3, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 6'b000000, 5'd3, 5'd4, 5'd5, 0, 1);
    chk("raw_stall_total0", cnt0, 32'd3);
    chk("raw_stall_total1", cnt1, 32'd2);

    // Writes to $0 and jumps never create hazards
    step(1, 6'b001000, 5'd1, 5'd0, 5'd0, 0, 1);
    step(1, 6'b000000, 5'd0, 5'd0, 5'd4, 0, 1);
    chk("zero_dest_nostall", so0, 32'd0);
    step(1, 6'b000010, 5'd6, 5'd6, 5'd6, 0, 1);
    step(1, 6'b000000, 5'd6, 5'd6, 5'd7, 0, 1);

    // Taken branch while a hazard is pending: flush wins, killed insn not tracked
    step(1, 6'b000000, 5'd1, 5'd1, 5'd10, 0, 1);
    step(1, 6'b000000, 5'd10, 5'd10, 5'd11, 1, 1);
    step(1, 6'b000000, 5'd11, 5'd0, 5'd12, 0, 1);
    chk("killed_insn_untracked", so0, 32'd0);
    step(1, 6'b000000, 5'd10, 5'd0, 5'd13, 0, 1);

    // Reset during second stall cycle
    step(0, 6'h00, 0, 0, 0, 0, 0);
    step(1, 6'b000000, 5'd1, 5'd2, 5'd3, 0, 1);
    step(1, 6'b000000, 5'd3, 5'd4, 5'd5, 0, 1);
    step(1, 6'b000000, 5'd3, 5'd4, 5'd5, 0, 0);
    step(1, 6'b000000, 5'd3, 5'd4, 5'd5, 0, 1);
    chk("rst_mid_stall_cnt0", cnt0, 32'd0);

    // Saturation of the narrow counter: 8 producer/consumer pairs
    step(0, 6'h00, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1, 6'b000000, 5'd2, 5'd3, 5'd1, 0, 1);
      for (int j = 0; j < 4; j++) step(1, 6'b000000, 5'd1, 5'd0, 5'd5, 0, 1);
    end
    chk("sat_cnt0", cnt0, 32'd15);
    chk("sat_cnt1", cnt1, 32'd16);

    // Random traffic over a small register set to provoke hazards
    cop = '0; crs = '0; crt = '0; crd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!last_s0) begin
        cop = ops[$urandom_range(0, 8)];
        crs = 5'($urandom_range(0, 3));
        crt = 5'($urandom_range(0, 3));
        crd = 5'($urandom_range(0, 3));
      end
      step(($urandom % 8) != 0, cop, crs, crt, crd, ($urandom % 12) == 0, ($urandom % 80) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
